// File: rtl/gpio_ctrl_pkg.sv
// Shared constants, FSM state type and register-map helpers
// for the GPIO ownership sequencer.
package gpio_ctrl_pkg;

    localparam int SEL_W         = 4;
    localparam int PINS_PER_WORD = 8;
    localparam int NUM_WORDS     = 5;

    localparam logic [7:0] OFF_SEL0   = 8'h00;
    localparam logic [7:0] OFF_SEL1   = 8'h04;
    localparam logic [7:0] OFF_SEL2   = 8'h08;
    localparam logic [7:0] OFF_SEL3   = 8'h0C;
    localparam logic [7:0] OFF_SEL4   = 8'h10;
    localparam logic [7:0] OFF_STATUS = 8'h14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_ACK
    } state_t;

    // Nibbles of select word k that map to real pins.
    function automatic logic [31:0] word_mask(int k, int npins);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < PINS_PER_WORD; i++) begin
            if (k * PINS_PER_WORD + i < npins) begin
                m[SEL_W*i +: SEL_W] = '1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_pin_mux.sv
// Per-pin owner mux: passes the selected team's out/oeb,
// or parks the pin (oeb=1, out=0) when unowned or isolated.
module gpio_pin_mux
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_TEAMS = 12
) (
    input  logic [SEL_W-1:0]     i_sel,
    input  logic                 i_iso,
    input  logic [NUM_TEAMS-1:0] i_tout,
    input  logic [NUM_TEAMS-1:0] i_toeb,
    output logic                 o_out,
    output logic                 o_oeb
);

    always_comb begin
        o_out = 1'b0;
        o_oeb = 1'b1;
        for (int t = 0; t < NUM_TEAMS; t++) begin
            if (!i_iso && i_sel == SEL_W'(t + 1)) begin
                o_out = i_tout[t];
                o_oeb = i_toeb[t];
            end
        end
    end

endmodule

// File: rtl/gpio_ownership_sequencer.sv
// Wishbone-configured GPIO owner selection with tri-state guard
// interval on every ownership change.
module gpio_ownership_sequencer
    import gpio_ctrl_pkg::*;
#(
    parameter int          NUM_TEAMS    = 12,
    parameter int          NUM_PINS     = 34,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_out,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_oeb,
    output logic [NUM_PINS-1:0]           gpio_out,
    output logic [NUM_PINS-1:0]           gpio_oeb,
    output logic                          busy
);

    localparam int CNT_W = $clog2(GUARD_CYCLES + 1);

    state_t             r_state;
    logic [31:0]        r_sel [NUM_WORDS];
    logic [31:0]        r_new;
    logic [2:0]         r_idx;
    logic [7:0]         r_mask;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sup;
    logic               r_ack;
    logic [31:0]        r_dat;

    logic [31:0] w_off;
    logic        w_is_sel;
    logic        w_is_stat;
    logic [2:0]  w_idx;
    logic [31:0] w_cur;
    logic [31:0] w_bm;
    logic [31:0] w_new;
    logic [7:0]  w_chg;
    logic [31:0] w_rdat;
    logic        w_req;

    assign w_off     = wbs_adr_i - BASE_ADDR;
    assign w_is_sel  = w_off < 32'(NUM_WORDS * 4);
    assign w_is_stat = w_off[31:2] == 30'(OFF_STATUS[7:2]);
    assign w_idx     = w_off[4:2];
    assign w_cur     = w_is_sel ? r_sel[w_idx] : '0;
    assign w_req     = wbs_cyc_i && wbs_stb_i;

    always_comb begin
        w_bm = '0;
        for (int b = 0; b < 4; b++) begin
            w_bm[8*b +: 8] = {8{wbs_sel_i[b]}};
        end
    end

    assign w_new = ((wbs_dat_i & w_bm) | (w_cur & ~w_bm))
                 & word_mask(int'(w_idx), NUM_PINS);

    always_comb begin
        w_chg = '0;
        for (int i = 0; i < PINS_PER_WORD; i++) begin
            w_chg[i] = w_new[SEL_W*i +: SEL_W] != w_cur[SEL_W*i +: SEL_W];
        end
    end

    always_comb begin
        w_rdat = '0;
        if (w_is_sel) begin
            w_rdat = w_cur;
        end else if (w_is_stat) begin
            w_rdat = {31'b0, r_state == ST_ISOLATE};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_sel[k] <= '0;
            end
            r_new <= '0;
            r_idx <= '0;
            r_mask <= '0;
            r_cnt <= '0;
            r_sup <= 1'b0;
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    if (w_req && !wbs_we_i) begin
                        r_dat <= w_rdat;
                        r_ack <= 1'b1;
                        r_state <= ST_ACK;
                    end else if (w_req && w_is_sel && |w_chg) begin
                        r_new <= w_new;
                        r_mask <= w_chg;
                        r_idx <= w_idx;
                        r_cnt <= CNT_W'(GUARD_CYCLES - 1);
                        r_sup <= 1'b0;
                        r_state <= ST_ISOLATE;
                    end else if (w_req) begin
                        if (w_is_sel) begin
                            r_sel[w_idx] <= w_new;
                        end
                        r_ack <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                ST_ISOLATE: begin
                    // A dropped cycle still commits, just silently.
                    if (!wbs_cyc_i) begin
                        r_sup <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_sel[r_idx] <= r_new;
                        r_mask <= '0;
                        r_ack <= !r_sup && wbs_cyc_i;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    r_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign busy      = r_state == ST_ISOLATE;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [NUM_TEAMS-1:0] w_tout;
        logic [NUM_TEAMS-1:0] w_toeb;
        for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
            assign w_tout[t] = designs_gpio_out[t*NUM_PINS + p];
            assign w_toeb[t] = designs_gpio_oeb[t*NUM_PINS + p];
        end
        gpio_pin_mux #(
            .NUM_TEAMS(NUM_TEAMS)
        ) u_mux (
            .i_sel  (r_sel[p/PINS_PER_WORD][SEL_W*(p%PINS_PER_WORD) +: SEL_W]),
            .i_iso  (r_mask[p%PINS_PER_WORD] && r_idx == 3'(p/PINS_PER_WORD)),
            .i_tout (w_tout),
            .i_toeb (w_toeb),
            .o_out  (gpio_out[p]),
            .o_oeb  (gpio_oeb[p])
        );
    end

endmodule

// File: tb/tb_gpio_ownership_sequencer.sv
// Scoreboard bench for gpio_ownership_sequencer: driver queues
// expected acks, a negedge monitor pops and compares them.
module tb_gpio_ownership_sequencer;

    localparam int          NT   = 12;
    localparam int          NP   = 34;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic           clk;
    logic           nrst;
    logic           wbs_stb_i;
    logic           wbs_cyc_i;
    logic           wbs_we_i;
    logic [3:0]     wbs_sel_i;
    logic [31:0]    wbs_adr_i;
    logic [31:0]    wbs_dat_i;
    logic           wbs_ack_o;
    logic [31:0]    wbs_dat_o;
    logic [NT*NP-1:0] designs_gpio_out;
    logic [NT*NP-1:0] designs_gpio_oeb;
    logic [NP-1:0]  gpio_out;
    logic [NP-1:0]  gpio_oeb;
    logic           busy;

    logic [NP-1:0]  dout [NT];
    logic [NP-1:0]  doeb [NT];
    logic [31:0]    m_word [5];

    typedef struct {
        bit          we;
        logic [31:0] dat;
        int          lat;
        int          issue;
    } sb_t;
    sb_t sb_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int ack_n = 0;
    int last_ack = 0;
    int busy_n = 0;
    int iso_bad = 0;
    bit watch = 0;

    gpio_ownership_sequencer #(
        .NUM_TEAMS(NT),
        .NUM_PINS(NP),
        .GUARD_CYCLES(4),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .designs_gpio_out(designs_gpio_out),
        .designs_gpio_oeb(designs_gpio_oeb),
        .gpio_out(gpio_out),
        .gpio_oeb(gpio_oeb),
        .busy(busy)
    );

    always_comb begin
        designs_gpio_out = '0;
        designs_gpio_oeb = '0;
        for (int t = 0; t < NT; t++) begin
            designs_gpio_out[t*NP +: NP] = dout[t];
            designs_gpio_oeb[t*NP +: NP] = doeb[t];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        if (wbs_ack_o) begin
            sb_t it;
            ack_n++;
            last_ack = cyc_n;
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc_n);
            end else begin
                it = sb_q.pop_front();
                chk("ack_latency", 64'(cyc_n - it.issue), 64'(it.lat));
                if (!it.we) begin
                    chk("read_data", 64'(wbs_dat_o), 64'(it.dat));
                end
            end
        end
        if (busy) begin
            busy_n++;
            if (watch && (gpio_oeb[3] !== 1'b1 || gpio_out[3] !== 1'b0)) begin
                iso_bad++;
            end
        end
    end

    task automatic bus_idle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
    endtask

    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp, input int lat);
        int n;
        @(posedge clk);
        #1;
        sb_q.push_back('{we, exp, lat, cyc_n});
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wbs_ack_o && n < 40);
        if (!wbs_ack_o) begin
            n_chk++;
            $display("FAIL ack_timeout: got no ack at %h expected ack within 40 cycles", adr);
            void'(sb_q.pop_back());
        end
        bus_idle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_pins(input string nm);
        logic [NP-1:0] eo;
        logic [NP-1:0] ee;
        int s;
        for (int p = 0; p < NP; p++) begin
            s = int'(m_word[p/8][4*(p%8) +: 4]);
            if (s >= 1 && s <= NT) begin
                eo[p] = dout[s-1][p];
                ee[p] = doeb[s-1][p];
            end else begin
                eo[p] = 1'b0;
                ee[p] = 1'b1;
            end
        end
        chk({nm, "_out"}, 64'(gpio_out), 64'(eo));
        chk({nm, "_oeb"}, 64'(gpio_oeb), 64'(ee));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1);
    end

    initial begin
        int b0;
        int a0;
        int w;
        nrst = 1'b0;
        bus_idle();
        for (int t = 0; t < NT; t++) begin
            dout[t] = NP'((t + 1) * 64'h0_9E37_79B9);
            doeb[t] = dout[t] ^ 34'h1_0F0F_0F0F;
        end
        for (int k = 0; k < 5; k++) m_word[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        chk("rst_out", 64'(gpio_out), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ack", 64'(wbs_ack_o), 64'h0);
        chk("rst_dat", 64'(wbs_dat_o), 64'h0);
        for (int k = 0; k < 6; k++) xfer(0, BASE + 32'(4*k), '0, 4'hF, 32'h0, 1);

        // pin 3 -> team 2
        b0 = busy_n;
        a0 = ack_n;
        xfer(1, BASE, 32'h0000_2000, 4'b0011, '0, 5);
        chk("assign_busy_cycles", 64'(busy_n - b0), 64'd4);
        chk("assign_one_ack", 64'(ack_n - a0), 64'd1);
        m_word[0] = 32'h0000_2000;
        check_pins("assign");
        dout[1][3] = 1'b1;
        #1;
        chk("follow_hi", 64'(gpio_out[3]), 64'h1);
        dout[1][3] = 1'b0;
        #1;
        chk("follow_lo", 64'(gpio_out[3]), 64'h0);

        b0 = busy_n;
        xfer(1, BASE, 32'h0000_2000, 4'b0011, '0, 1);
        chk("redundant_busy", 64'(busy_n - b0), 64'd0);
        check_pins("redundant");

        xfer(1, BASE + 32'h4, 32'hFFFF_FFFF, 4'b0100, '0, 5);
        m_word[1] = 32'h00FF_0000;
        xfer(0, BASE + 32'h4, '0, 4'hF, 32'h00FF_0000, 1);
        chk("bytesel_oeb", 64'(gpio_oeb[13:12]), 64'h3);
        check_pins("bytesel");

        // pin 3: team 2 (driving oeb=0) -> team 5, must park during guard
        doeb[1][3] = 1'b0;
        #1;
        chk("pre_reassign_oeb", 64'(gpio_oeb[3]), 64'h0);
        b0 = busy_n;
        iso_bad = 0;
        watch = 1;
        xfer(1, BASE, 32'h0000_5000, 4'b0010, '0, 5);
        watch = 0;
        w = last_ack;
        chk("iso_parked", 64'(iso_bad), 64'h0);
        chk("reassign_busy", 64'(busy_n - b0), 64'd4);
        xfer(0, BASE + 32'h14, '0, 4'hF, 32'h0, 1);
        chk("status_gap", 64'(last_ack - w), 64'd2);
        m_word[0] = 32'h0000_5000;
        check_pins("reassign");

        // bus abort mid-guard: commit, no ack
        a0 = ack_n;
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i = 1'b1;
        wbs_sel_i = 4'b0001;
        wbs_adr_i = BASE + 32'h8;
        wbs_dat_i = 32'h0000_0003;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'h1);
        bus_idle();
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_ack", 64'(ack_n - a0), 64'd0);
        m_word[2] = 32'h0000_0003;
        xfer(0, BASE + 32'h8, '0, 4'hF, 32'h0000_0003, 1);
        check_pins("abort");

        xfer(1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, '0, 5);
        m_word[4] = 32'h0000_00FF;
        xfer(0, BASE + 32'h10, '0, 4'hF, 32'h0000_00FF, 1);
        check_pins("word4");

        xfer(0, BASE + 32'h40, '0, 4'hF, 32'h0, 1);
        xfer(1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, '0, 1);
        xfer(0, BASE + 32'h18, '0, 4'hF, 32'h0, 1);

        // reset during ISOLATE cycle 2
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i = 1'b1;
        wbs_sel_i = 4'b0001;
        wbs_adr_i = BASE;
        wbs_dat_i = 32'h0000_5001;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midrst_busy_before", 64'(busy), 64'h1);
        nrst = 1'b0;
        #1;
        bus_idle();
        chk("midrst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        chk("midrst_out", 64'(gpio_out), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) m_word[k] = '0;
        for (int k = 0; k < 5; k++) xfer(0, BASE + 32'(4*k), '0, 4'hF, 32'h0, 1);
        check_pins("after_rst");

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
